// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one load/store at a
// time, waits LATENCY cycles, then pulses rsp_valid with read data or a store ack.
module dm_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  // Handshake: a request transfers on any posedge where req_valid && req_ready.
  // The response is a single-cycle rsp_valid strobe with no backpressure.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                access;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                in_range;
  logic                mem_we;
  logic [DEPTH_LOG2-1:0] mem_idx;

  assign req_ready = (state_q != ST_WAIT);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q == ST_WAIT);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = '0;
    err_d     = 1'b0;
    access    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            // Single-cycle build: the accept edge is also the RESP entry edge,
            // so the memory is accessed with the live request fields.
            state_d   = ST_RESP;
            access    = 1'b1;
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_range = ((acc_addr >> DEPTH_LOG2) == '0);
    mem_idx  = acc_addr[DEPTH_LOG2-1:0];
    mem_we   = access && acc_we && in_range;

    if (access) begin
      if (!in_range) begin
        err_d = 1'b1;
      end else if (!acc_we) begin
        rdata_d = mem_q[mem_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately not cleared; reset only blocks a pending store.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[mem_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a LATENCY=3 and a LATENCY=1 instance, each with
// an expected-response queue checked by a monitor at every falling edge.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        v3, v1;

  logic        rdy3, val3, err3, busy3;
  logic [15:0] rdata3;
  logic        rdy1, val1, err1, busy1;
  logic [15:0] rdata1;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  // {stamp[31:0], err, rdata[15:0]}
  logic [48:0] exp3_q[$];
  logic [48:0] exp1_q[$];
  logic [48:0] e3, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy3), .rsp_valid(val3), .rsp_rdata(rdata3),
    .rsp_err(err3), .busy(busy3)
  );

  dm_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy1), .rsp_valid(val1), .rsp_rdata(rdata1),
    .rsp_err(err1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic issue(input bit sel, input logic we, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] exp_d, input logic exp_e);
    int n;
    n = 0;
    while (!(sel ? rdy1 : rdy3)) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("issue_timeout", {31'd0, sel ? rdy1 : rdy3}, 32'd1);
        return;
      end
    end
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    if (sel) begin
      v1 = 1'b1;
      exp1_q.push_back({32'(cyc + 1), exp_e, exp_d});
    end else begin
      v3 = 1'b1;
      exp3_q.push_back({32'(cyc + 3), exp_e, exp_d});
    end
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    v3 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (val3) begin
        if (exp3_q.size() == 0) begin
          chk("l3_unexpected_rsp", {31'd0, val3}, 32'd0);
        end else begin
          e3 = exp3_q.pop_front();
          chk("l3_rsp_cycle", cyc, e3[48:17]);
          chk("l3_rsp_err", {31'd0, err3}, {31'd0, e3[16]});
          chk("l3_rsp_rdata", {16'd0, rdata3}, {16'd0, e3[15:0]});
        end
      end else begin
        chk("l3_idle_outputs", {15'd0, err3, rdata3}, 32'd0);
        if (exp3_q.size() != 0 && exp3_q[0][48:17] < 32'(cyc)) begin
          void'(exp3_q.pop_front());
          chk("l3_rsp_missing", {31'd0, val3}, 32'd1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("l1_busy_never", {31'd0, busy1}, 32'd0);
      if (val1) begin
        if (exp1_q.size() == 0) begin
          chk("l1_unexpected_rsp", {31'd0, val1}, 32'd0);
        end else begin
          e1 = exp1_q.pop_front();
          chk("l1_rsp_cycle", cyc, e1[48:17]);
          chk("l1_rsp_err", {31'd0, err1}, {31'd0, e1[16]});
          chk("l1_rsp_rdata", {16'd0, rdata1}, {16'd0, e1[15:0]});
        end
      end else begin
        chk("l1_idle_outputs", {15'd0, err1, rdata1}, 32'd0);
        if (exp1_q.size() != 0 && exp1_q[0][48:17] < 32'(cyc)) begin
          void'(exp1_q.pop_front());
          chk("l1_rsp_missing", {31'd0, val1}, 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    v3 = 1'b0;
    v1 = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, rdy3}, 32'd1);
    chk("rst_valid", {31'd0, val3}, 32'd0);
    chk("rst_rdata", {16'd0, rdata3}, 32'd0);
    chk("rst_err", {31'd0, err3}, 32'd0);
    chk("rst_busy", {31'd0, busy3}, 32'd0);
    chk("rst_l1_ready", {31'd0, rdy1}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Store 0xBEEF to 5: two busy cycles, then RESP with ready high.
    issue(0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0);
    chk("st_busy_c1", {31'd0, busy3}, 32'd1);
    chk("st_ready_c1", {31'd0, rdy3}, 32'd0);
    @(negedge clk);
    chk("st_busy_c2", {31'd0, busy3}, 32'd1);
    @(negedge clk);
    chk("st_busy_resp", {31'd0, busy3}, 32'd0);
    chk("st_ready_resp", {31'd0, rdy3}, 32'd1);
    chk("st_valid_resp", {31'd0, val3}, 32'd1);
    c0 = cyc;
    issue(0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0);
    chk("b2b_accept_at_once", cyc - c0, 32'd1);

    issue(0, 1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0);
    issue(0, 1'b1, 16'h0009, 16'h0909, 16'h0000, 1'b0);

    // Out-of-range store is suppressed and flagged.
    issue(0, 1'b1, 16'h0400, 16'h1234, 16'h0000, 1'b1);
    issue(0, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0);
    issue(0, 1'b0, 16'h8400, 16'h0000, 16'h0000, 1'b1);

    // Inputs toggled during WAIT must be ignored.
    issue(0, 1'b0, 16'h0009, 16'h0000, 16'h0909, 1'b0);
    v3 = 1'b1; req_we = 1'b1; req_addr = 16'h0009; req_wdata = 16'hDEAD;
    chk("wait_ready_low1", {31'd0, rdy3}, 32'd0);
    @(negedge clk);
    req_addr = 16'h0005; req_wdata = 16'h5555;
    chk("wait_ready_low2", {31'd0, rdy3}, 32'd0);
    @(negedge clk);
    v3 = 1'b0;
    issue(0, 1'b0, 16'h0009, 16'h0000, 16'h0909, 1'b0);
    issue(0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0);

    // Reset one cycle after a store accept drops it.
    issue(0, 1'b1, 16'h0007, 16'h7777, 16'h0000, 1'b0);
    issue(0, 1'b1, 16'h0007, 16'hAAAA, 16'h0000, 1'b0);
    rst_n = 1'b0;
    exp3_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", {31'd0, val3}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy3}, 32'd0);
    chk("mid_rst_ready", {31'd0, rdy3}, 32'd1);
    repeat (5) @(negedge clk);
    issue(0, 1'b0, 16'h0007, 16'h0000, 16'h7777, 1'b0);

    // LATENCY=1 instance: back-to-back load stream.
    issue(1, 1'b1, 16'h0000, 16'hA0A0, 16'h0000, 1'b0);
    issue(1, 1'b1, 16'h0001, 16'hA1A1, 16'h0000, 1'b0);
    issue(1, 1'b1, 16'h0002, 16'hA2A2, 16'h0000, 1'b0);
    c0 = cyc;
    issue(1, 1'b0, 16'h0000, 16'h0000, 16'hA0A0, 1'b0);
    issue(1, 1'b0, 16'h0001, 16'h0000, 16'hA1A1, 1'b0);
    issue(1, 1'b0, 16'h0002, 16'h0000, 16'hA2A2, 1'b0);
    chk("l1_stream_cycles", cyc - c0, 32'd3);
    issue(1, 1'b1, 16'h0500, 16'h5A5A, 16'h0000, 1'b1);

    repeat (6) @(negedge clk);
    chk("l3_queue_drained", exp3_q.size(), 32'd0);
    chk("l1_queue_drained", exp1_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
